// File: rtl/apb_node_pkg.sv
// Shared types for the APB peripheral node: FSM state encoding and error-log counter sizing.
package apb_node_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } node_state_e;

  localparam int ERR_CNT_W = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

endpackage

// File: rtl/apb_node_decoder.sv
// Combinational address matcher: inclusive [start, end] windows, lowest index wins on overlap.
module apb_node_decoder #(
  parameter int NB_MASTER  = 10,
  parameter int ADDR_WIDTH = 32,
  parameter int IDX_WIDTH  = (NB_MASTER > 1) ? $clog2(NB_MASTER) : 1
) (
  input  logic [ADDR_WIDTH-1:0]                start_addr_unused_guard_i,
  input  logic [ADDR_WIDTH-1:0]                addr_i,
  input  logic [NB_MASTER-1:0][ADDR_WIDTH-1:0] start_addr_i,
  input  logic [NB_MASTER-1:0][ADDR_WIDTH-1:0] end_addr_i,
  output logic                                 hit_o,
  output logic [IDX_WIDTH-1:0]                 idx_o
);

  logic [ADDR_WIDTH-1:0] guard_unused;

  assign guard_unused = start_addr_unused_guard_i;

  // Scanning downwards lets the lowest matching index overwrite any higher one.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = NB_MASTER - 1; i >= 0; i--) begin
      if ((start_addr_i[i] <= addr_i) && (addr_i <= end_addr_i[i])) begin
        hit_o = 1'b1;
        idx_o = IDX_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/apb_periph_node.sv
// Registered APB fan-out node with runtime address map, decode-miss error and ACCESS timeout.
// Optional error logger (err_addr_o/err_cnt_o/err_sticky_o/err_clr_i) enabled by APB_NODE_ERR_LOG_EN.
module apb_periph_node
  import apb_node_pkg::*;
#(
  parameter int NB_MASTER      = 10,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic [APB_ADDR_WIDTH-1:0]                s_paddr_i,
  input  logic [APB_DATA_WIDTH-1:0]                s_pwdata_i,
  input  logic                                     s_pwrite_i,
  input  logic                                     s_psel_i,
  input  logic                                     s_penable_i,
  output logic [APB_DATA_WIDTH-1:0]                s_prdata_o,
  output logic                                     s_pready_o,
  output logic                                     s_pslverr_o,
  output logic [APB_ADDR_WIDTH-1:0]                m_paddr_o,
  output logic [APB_DATA_WIDTH-1:0]                m_pwdata_o,
  output logic                                     m_pwrite_o,
  output logic [NB_MASTER-1:0]                     m_psel_o,
  output logic                                     m_penable_o,
  input  logic [NB_MASTER-1:0][APB_DATA_WIDTH-1:0] m_prdata_i,
  input  logic [NB_MASTER-1:0]                     m_pready_i,
  input  logic [NB_MASTER-1:0]                     m_pslverr_i,
  input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] start_addr_i,
  input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] end_addr_i
`ifdef APB_NODE_ERR_LOG_EN
  ,
  input  logic                                     err_clr_i,
  output logic [APB_ADDR_WIDTH-1:0]                err_addr_o,
  output logic [ERR_CNT_W-1:0]                     err_cnt_o,
  output logic                                     err_sticky_o
`endif
);

  localparam int IDX_W  = (NB_MASTER > 1) ? $clog2(NB_MASTER) : 1;
  localparam int TCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

  node_state_e                state_q, state_d;
  logic [APB_ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [APB_DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic                       write_q, write_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [NB_MASTER-1:0]       psel_q, psel_d;
  logic                       penable_q, penable_d;
  logic [APB_DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic                       err_q, err_d;
  logic [TCNT_W-1:0]          tcnt_q, tcnt_d;

  logic                       dec_hit;
  logic [IDX_W-1:0]           dec_idx;
  logic                       setup_cyc;
  logic                       resp_ok;

  apb_node_decoder #(
    .NB_MASTER (NB_MASTER),
    .ADDR_WIDTH(APB_ADDR_WIDTH),
    .IDX_WIDTH (IDX_W)
  ) u_decoder (
    .start_addr_unused_guard_i(s_paddr_i),
    .addr_i                   (s_paddr_i),
    .start_addr_i             (start_addr_i),
    .end_addr_i               (end_addr_i),
    .hit_o                    (dec_hit),
    .idx_o                    (dec_idx)
  );

  assign setup_cyc = s_psel_i & ~s_penable_i;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    idx_d     = idx_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    tcnt_d    = tcnt_q;
    unique case (state_q)
      IDLE: begin
        if (setup_cyc) begin
          if (dec_hit) begin
            state_d         = SETUP;
            addr_d          = s_paddr_i;
            wdata_d         = s_pwdata_i;
            write_d         = s_pwrite_i;
            idx_d           = dec_idx;
            psel_d          = '0;
            psel_d[dec_idx] = 1'b1;
            penable_d       = 1'b0;
            tcnt_d          = '0;
          end else begin
            state_d = RESP;
            rdata_d = '0;
            err_d   = 1'b1;
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (m_pready_i[idx_q]) begin
          state_d   = RESP;
          rdata_d   = write_q ? '0 : m_prdata_i[idx_q];
          err_d     = m_pslverr_i[idx_q];
          psel_d    = '0;
          penable_d = 1'b0;
        end else if ((TIMEOUT_CYCLES != 0) && (tcnt_q == TCNT_LAST)) begin
          state_d   = RESP;
          rdata_d   = '0;
          err_d     = 1'b1;
          psel_d    = '0;
          penable_d = 1'b0;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      RESP: begin
        // The response is offered for one cycle only; a dropped psel simply discards it.
        state_d = IDLE;
        rdata_d = '0;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      idx_q     <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      tcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      idx_q     <= idx_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      tcnt_q    <= tcnt_d;
    end
  end

  assign resp_ok     = (state_q == RESP) & s_psel_i & s_penable_i;
  assign s_pready_o  = resp_ok;
  assign s_prdata_o  = resp_ok ? rdata_q : '0;
  assign s_pslverr_o = resp_ok & err_q;

  assign m_paddr_o   = addr_q;
  assign m_pwdata_o  = wdata_q;
  assign m_pwrite_o  = write_q;
  assign m_psel_o    = psel_q;
  assign m_penable_o = penable_q;

`ifdef APB_NODE_ERR_LOG_EN
  logic [APB_ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic [ERR_CNT_W-1:0]      err_cnt_q, err_cnt_d;
  logic                      err_sticky_q, err_sticky_d;
  logic                      err_evt;

  // An error is logged on the edge that enters RESP with pslverr set; clear has priority.
  always_comb begin
    err_evt      = (state_q != RESP) && (state_d == RESP) && err_d;
    err_addr_d   = err_addr_q;
    err_cnt_d    = err_cnt_q;
    err_sticky_d = err_sticky_q;
    if (err_clr_i) begin
      err_addr_d   = '0;
      err_cnt_d    = '0;
      err_sticky_d = 1'b0;
    end else if (err_evt) begin
      err_addr_d   = (state_q == IDLE) ? s_paddr_i : addr_q;
      err_sticky_d = 1'b1;
      if (err_cnt_q != ERR_CNT_MAX) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_addr_q   <= '0;
      err_cnt_q    <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      err_addr_q   <= err_addr_d;
      err_cnt_q    <= err_cnt_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign err_addr_o   = err_addr_q;
  assign err_cnt_o    = err_cnt_q;
  assign err_sticky_o = err_sticky_q;
`endif

endmodule
